// File: rtl/hazard_stall_if.sv
// Pipeline-side bundle for the hazard/stall unit: the decode, EX and MEM
// fields the unit inspects plus the hold/bubble/flush controls it returns.
interface hazard_stall_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      ifid_Instr;
    logic             ifid_UsesRs;
    logic             ifid_UsesRt;
    logic             idex_MemRead;
    logic             idex_RegWriteEn;
    logic [2:0]       idex_RegD;
    logic             exmem_MemAccess;
    logic             dmem_Done;
    logic             exmem_BranchTaken;

    logic             pc_hold;
    logic             ifid_hold;
    logic             idex_hold;
    logic             exmem_hold;
    logic             idex_bubble;
    logic             memwb_bubble;
    logic             ifid_flush;
    logic             idex_flush;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cycles;

    // Pipeline side: presents stage fields, consumes controls.
    modport master (
        output ifid_Instr, ifid_UsesRs, ifid_UsesRt,
        output idex_MemRead, idex_RegWriteEn, idex_RegD,
        output exmem_MemAccess, dmem_Done, exmem_BranchTaken,
        input  pc_hold, ifid_hold, idex_hold, exmem_hold,
        input  idex_bubble, memwb_bubble, ifid_flush, idex_flush,
        input  timeout_err, stall_cycles
    );

    // Hazard unit side: consumes stage fields, produces controls.
    modport slave (
        input  ifid_Instr, ifid_UsesRs, ifid_UsesRt,
        input  idex_MemRead, idex_RegWriteEn, idex_RegD,
        input  exmem_MemAccess, dmem_Done, exmem_BranchTaken,
        output pc_hold, ifid_hold, idex_hold, exmem_hold,
        output idex_bubble, memwb_bubble, ifid_flush, idex_flush,
        output timeout_err, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Hazard/stall unit beside decode: holds the pipeline during data-memory
// waits, flushes IF/ID and ID/EX on a taken branch, and inserts one bubble
// on a load-use dependency. Controls are combinational so they act in the
// same cycle; a sticky timeout flag and a saturating stall counter are kept.
module hazard_stall_unit #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_stall_if.slave bus
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    logic [0:0]        state_r;
    logic [0:0]        state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;
    logic              timeout_err_r;
    logic [CNT_W-1:0]  stall_cycles_r;

    logic              mem_wait_s;
    logic              rs_match_s;
    logic              rt_match_s;
    logic              load_use_s;

    logic              pc_hold_s;
    logic              ifid_hold_s;
    logic              idex_hold_s;
    logic              exmem_hold_s;
    logic              idex_bubble_s;
    logic              memwb_bubble_s;
    logic              ifid_flush_s;
    logic              idex_flush_s;

    // Only the Rs/Rt fields of the decode instruction matter here.
    logic              unused_instr_bits_s;
    assign unused_instr_bits_s = ^{bus.ifid_Instr[15:11], bus.ifid_Instr[4:0]};

    // Hazard conditions: a pending memory access, and a load in EX feeding decode.
    always_comb begin
        mem_wait_s = ((state_r == ST_MEM_WAIT) || bus.exmem_MemAccess) && !bus.dmem_Done;
        rs_match_s = bus.ifid_UsesRs && (bus.idex_RegD == bus.ifid_Instr[10:8]);
        rt_match_s = bus.ifid_UsesRt && (bus.idex_RegD == bus.ifid_Instr[7:5]);
        load_use_s = bus.idex_MemRead && bus.idex_RegWriteEn && (rs_match_s || rt_match_s);
    end

    // Prioritised control decode; reset forces every control low at once,
    // even while an access is still being presented.
    always_comb begin
        pc_hold_s      = 1'b0;
        ifid_hold_s    = 1'b0;
        idex_hold_s    = 1'b0;
        exmem_hold_s   = 1'b0;
        idex_bubble_s  = 1'b0;
        memwb_bubble_s = 1'b0;
        ifid_flush_s   = 1'b0;
        idex_flush_s   = 1'b0;
        if (!rst_n) begin
            pc_hold_s = 1'b0;
        end else if (mem_wait_s) begin
            // Freeze everything up to MEM; branch/load-use inputs stay stable
            // and are re-evaluated once the access completes.
            pc_hold_s      = 1'b1;
            ifid_hold_s    = 1'b1;
            idex_hold_s    = 1'b1;
            exmem_hold_s   = 1'b1;
            memwb_bubble_s = 1'b1;
        end else if (bus.exmem_BranchTaken) begin
            // The would-be consumer is squashed, so no load-use stall.
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else if (load_use_s) begin
            pc_hold_s     = 1'b1;
            ifid_hold_s   = 1'b1;
            idex_bubble_s = 1'b1;
        end else begin
            pc_hold_s = 1'b0;
        end
    end

    // Next-state logic for the RUN / MEM_WAIT machine.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (bus.exmem_MemAccess && !bus.dmem_Done) begin
                    state_nxt_s = ST_MEM_WAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.dmem_Done) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_MEM_WAIT;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Wait counter counts elapsed wait cycles, saturates at the timeout,
    // and clears as soon as the wait ends.
    always_comb begin
        wait_cnt_nxt_s = wait_cnt_r;
        if (mem_wait_s) begin
            if (wait_cnt_r == WAIT_MAX) begin
                wait_cnt_nxt_s = wait_cnt_r;
            end else begin
                wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
            end
        end else begin
            wait_cnt_nxt_s = {WAIT_W{1'b0}};
        end
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_RUN;
            wait_cnt_r    <= {WAIT_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            if (mem_wait_s && (wait_cnt_nxt_s == WAIT_MAX)) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_r <= {CNT_W{1'b0}};
        end else if (pc_hold_s && (stall_cycles_r != CNT_MAX)) begin
            stall_cycles_r <= stall_cycles_r + CNT_W'(1);
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign bus.pc_hold      = pc_hold_s;
    assign bus.ifid_hold    = ifid_hold_s;
    assign bus.idex_hold    = idex_hold_s;
    assign bus.exmem_hold   = exmem_hold_s;
    assign bus.idex_bubble  = idex_bubble_s;
    assign bus.memwb_bubble = memwb_bubble_s;
    assign bus.ifid_flush   = ifid_flush_s;
    assign bus.idex_flush   = idex_flush_s;
    assign bus.timeout_err  = timeout_err_r;
    assign bus.stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with a small expectation scoreboard.
module tb_hazard_stall_unit;

    localparam int CNT_W = 16;

    // Control vector order: pc, ifid, idex, exmem holds, idex/memwb bubbles, flushes.
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_LU   = 8'b1100_1000;
    localparam logic [7:0] C_MW   = 8'b1111_0100;
    localparam logic [7:0] C_BR   = 8'b0000_0011;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb_q[$];
    int   n_pass;
    int   n_total;
    int   exp_stall;
    logic [7:0] ctrl_obs;

    hazard_stall_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_unit #(.MEM_TIMEOUT(5), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign ctrl_obs = {bus.pc_hold, bus.ifid_hold, bus.idex_hold, bus.exmem_hold,
                       bus.idex_bubble, bus.memwb_bubble, bus.ifid_flush, bus.idex_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [15:0] obs);
        exp_t e;
        n_total++;
        if (sb_q.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic drive(input logic [15:0] instr, input logic urs, input logic urt,
                         input logic mrd, input logic rwe, input logic [2:0] rd,
                         input logic acc, input logic done, input logic br);
        bus.ifid_Instr        = instr;
        bus.ifid_UsesRs       = urs;
        bus.ifid_UsesRt       = urt;
        bus.idex_MemRead      = mrd;
        bus.idex_RegWriteEn   = rwe;
        bus.idex_RegD         = rd;
        bus.exmem_MemAccess   = acc;
        bus.dmem_Done         = done;
        bus.exmem_BranchTaken = br;
    endtask

    task automatic idle();
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Inputs are applied at a falling edge; controls are checked 2 time units
    // later and then one rising edge is taken.
    task automatic step(input string tag, input logic [7:0] exp_ctrl);
        push_exp(tag, {8'h00, exp_ctrl});
        #2;
        pop_check({8'h00, ctrl_obs});
        if (exp_ctrl[7]) exp_stall++;
        @(negedge clk);
    endtask

    task automatic check_stats(input string tag, input logic exp_terr);
        push_exp({tag, "_terr"}, {15'd0, exp_terr});
        pop_check({15'd0, bus.timeout_err});
        push_exp({tag, "_cnt"}, 16'(exp_stall));
        pop_check(bus.stall_cycles);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        exp_stall = 0;
        rst_n     = 1'b0;
        idle();
        #2;
        push_exp("reset_ctrl", 16'h0000);
        pop_check({8'h00, ctrl_obs});
        check_stats("reset", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        idle();                                          step("idle", C_NONE);

        // Load-use through Rs (Rs = r3)
        drive(16'h0300, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        step("lu_rs", C_LU);
        idle();                                          step("lu_rs_after", C_NONE);
        check_stats("lu_rs", 1'b0);

        // Rt matches but is not read, then is read
        drive(16'h0060, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        step("rt_unused", C_NONE);
        drive(16'h0060, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        step("lu_rt", C_LU);
        idle();                                          step("lu_rt_after", C_NONE);
        check_stats("lu_rt", 1'b0);

        // R0 dependency still stalls; non-writing load does not
        drive(16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        step("lu_r0", C_LU);
        drive(16'h0300, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
        step("no_regwrite", C_NONE);
        drive(16'h0300, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        step("not_load", C_NONE);
        check_stats("r0", 1'b0);

        // Four-cycle memory wait, then completion
        for (int k = 1; k <= 4; k++) begin
            drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
            step($sformatf("mw4_%0d", k), C_MW);
        end
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        step("mw4_done", C_NONE);
        idle();                                          step("mw4_after", C_NONE);
        check_stats("mw4", 1'b0);

        // Zero-wait access
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        step("mw0", C_NONE);

        // Branch beats load-use
        drive(16'h0300, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1);
        step("br_lu", C_BR);
        idle();                                          step("br_after", C_NONE);
        check_stats("br", 1'b0);

        // Memory wait beats branch; flush appears on the Done cycle
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
        step("mw_br_1", C_MW);
        step("mw_br_2", C_MW);
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
        step("mw_br_done", C_BR);
        idle();                                          step("mw_br_after", C_NONE);
        check_stats("mw_br", 1'b0);

        // Timeout: eight wait cycles with MEM_TIMEOUT = 5
        for (int k = 1; k <= 8; k++) begin
            drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
            step($sformatf("to_%0d", k), C_MW);
            check_stats($sformatf("to_%0d", k), logic'(k >= 5));
        end
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        step("to_done", C_NONE);
        idle();                                          step("to_after", C_NONE);
        check_stats("to_after", 1'b1);

        // Reset in the middle of a wait
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        step("rst_mw_1", C_MW);
        step("rst_mw_2", C_MW);
        rst_n     = 1'b0;
        exp_stall = 0;
        #1;
        push_exp("rst_mid_ctrl", 16'h0000);
        pop_check({8'h00, ctrl_obs});
        check_stats("rst_mid", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_mw", C_MW);
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        step("post_rst_done", C_NONE);
        check_stats("post_rst", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
